register_bank: RTL and testbench
================================

Name: register_bank

Overview:
Parametrised bank of DEPTH registers, each WIDTH bits wide. It generalises the single load-enable register into an addressed bank with these features:
- read-modify-write operations (load, set, clear, toggle, increment)
- per-register write lock
- a registered read port with write forwarding
- error and carry status pulses

Intended uses are bank registers, I/O shadow latches and control registers in the NU6509 core. All state changes on the falling clock edge.

Parameters:
WIDTH, 8, bits per register (1..32).
DEPTH, 4, number of registers (2..16).
ADDR_W, 2, address width; must satisfy 2**ADDR_W >= DEPTH.
RESET, 0, reset value of every register and of rdata.

Ports:
clock  input  1  system clock; all flops update on the negedge.
reset  input  1  asynchronous, active-high reset.
we  input  1  operation strobe; cmd is executed on the falling edge while we=1.
waddr  input  ADDR_W  target register of the operation.
cmd  input  3  operation code (see Behaviour).
wdata  input  WIDTH  operand.
raddr  input  ADDR_W  read address.
rdata  output  WIDTH  registered read data.
q_all  output  WIDTH*DEPTH  flattened register contents; register i occupies bits [i*WIDTH +: WIDTH]; combinational from state.
locked  output  DEPTH  per-register lock flags.
err  output  1  one-cycle pulse for a rejected operation.
carry  output  1  one-cycle pulse when an increment wraps.

Behaviour:
- Reset (async, any time, including mid-operation):
  - all registers = RESET, rdata = RESET
  - locked = 0, err = 0, carry = 0
  - the operation pending on that edge is discarded
- cmd encoding, applied to reg[waddr] on the negedge when we=1:
  - 000 load: reg = wdata
  - 001 set: reg = reg | wdata
  - 010 clear: reg = reg & ~wdata
  - 011 toggle: reg = reg ^ wdata
  - 100 increment: reg = reg + 1, mod 2**WIDTH; wdata ignored
  - 101 lock: locked[waddr] = 1; reg unchanged
  - 110 unlock: locked[waddr] = 0; reg unchanged
  - 111 nop: no change, no status pulse
- Lock rule:
  - if locked[waddr]=1, cmds 000-100 leave reg unchanged and err pulses
  - lock and unlock are always accepted
  - lock on an already-locked register: no error
- Address out of range (waddr >= DEPTH): no state change for any cmd except nop; err pulses.
- err and carry are registered. Each is high for exactly the one cycle (negedge to next negedge) following the offending or wrapping operation, then returns to 0 unless retriggered.
- carry rule:
  - pulses only when cmd=100 is accepted and the old value was 2**WIDTH-1; the register becomes 0
  - a rejected increment (locked or out-of-range) never sets carry
- we=0: registers and locked hold; err and carry return to 0.
- Read port:
  - rdata is sampled each negedge from raddr, giving 1-cycle latency
  - forwarding: if raddr==waddr and the same edge applies an accepted value-changing op, rdata takes the new value
  - raddr >= DEPTH: rdata = 0
- q_all and locked reflect state immediately after the edge; no forwarding is needed.
- Only one register changes per edge; there is a single write port.

Decomposition:
- Shared package register_pkg:
  - cmd localparams CMD_LOAD, CMD_SET, CMD_CLR, CMD_TGL, CMD_INC, CMD_LOCK, CMD_UNLOCK, CMD_NOP
  - a function computing next value from (cmd, old, wdata)
- One natural sub-module, register_cell: one WIDTH-bit register plus lock bit, async reset, negedge update, with inputs sel/cmd/wdata and outputs q/locked/wrap. It is instantiated DEPTH times via generate. The top level holds address decode, the read mux with forwarding, and the err/carry flops.

Test Plan:
1. WIDTH=8, DEPTH=4. Reset, then load 0xA5 to reg2, set 0x0F, clear 0x81, toggle 0xFF. reg2 sequence is 0xA5, 0xAF, 0x2E, 0xD1; err and carry stay 0 throughout.
2. Load 0xFE to reg1, then increment twice. reg1 goes 0xFF then 0x00; carry pulses exactly once, after the second increment.
3. Lock reg0, then load 0x55 to reg0: reg0 keeps its value and err pulses one cycle. Unlock, then load 0x55: reg0 = 0x55, no err.
4. DEPTH=3, ADDR_W=2: load to waddr=3 gives err pulse and q_all unchanged; raddr=3 gives rdata = 0.
5. raddr=waddr=1, load 0x3C on reg1: rdata = 0x3C after the same edge (forwarding). Repeat the load while reg1 is locked: rdata keeps the old value.
6. Assert reset asynchronously between edges, mid-sequence with we=1. All outputs go to RESET/0 immediately, with no clock edge needed, and the pending op is dropped after reset is released.

Source files
------------

// File: rtl/register_pkg.sv
// Shared command encoding and read-modify-write arithmetic for the register bank.
package register_pkg;

    localparam logic [2:0] CMD_LOAD   = 3'b000;
    localparam logic [2:0] CMD_SET    = 3'b001;
    localparam logic [2:0] CMD_CLR    = 3'b010;
    localparam logic [2:0] CMD_TGL    = 3'b011;
    localparam logic [2:0] CMD_INC    = 3'b100;
    localparam logic [2:0] CMD_LOCK   = 3'b101;
    localparam logic [2:0] CMD_UNLOCK = 3'b110;
    localparam logic [2:0] CMD_NOP    = 3'b111;

    // Computed at the maximum width; callers truncate to their own WIDTH,
    // which also makes the increment wrap modulo 2**WIDTH.
    function automatic logic [31:0] next_value(input logic [2:0]  cmd,
                                               input logic [31:0] old,
                                               input logic [31:0] wdata);
        case (cmd)
            CMD_LOAD: next_value = wdata;
            CMD_SET:  next_value = old | wdata;
            CMD_CLR:  next_value = old & ~wdata;
            CMD_TGL:  next_value = old ^ wdata;
            CMD_INC:  next_value = old + 32'd1;
            default:  next_value = old;
        endcase
    endfunction

endpackage

// File: rtl/register_cell.sv
// One bank register with its lock flag; updates on the falling clock edge.
module register_cell
    import register_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RESET = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sel,
    input  logic [2:0]       cmd,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] q,
    output logic             locked,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             locked_reg;
    logic             value_op;

    assign value_op = (cmd <= CMD_INC);
    assign q_next   = WIDTH'(next_value(cmd, 32'(q_reg), 32'(wdata)));

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            q_reg      <= RESET_VAL;
            locked_reg <= 1'b0;
        end else if (sel) begin
            if (cmd == CMD_LOCK)
                locked_reg <= 1'b1;
            else if (cmd == CMD_UNLOCK)
                locked_reg <= 1'b0;
            else if (value_op && !locked_reg)
                q_reg <= q_next;
        end
    end

    // Only an accepted increment of the all-ones value wraps.
    assign wrap   = sel && (cmd == CMD_INC) && !locked_reg && (q_reg == '1);
    assign q      = q_reg;
    assign locked = locked_reg;

endmodule

// File: rtl/register_bank.sv
// Addressed bank of lockable registers with a read-modify-write port,
// a registered forwarding read port and err/carry status pulses.
module register_bank
    import register_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int RESET  = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [2:0]             cmd,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [ADDR_W-1:0]      raddr,
    output logic [WIDTH-1:0]       rdata,
    output logic [WIDTH*DEPTH-1:0] q_all,
    output logic [DEPTH-1:0]       locked,
    output logic                   err,
    output logic                   carry
);

    localparam int               SLOTS     = 1 << ADDR_W;
    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET);

    // Unpopulated address slots read as zero, so out-of-range reads need no special case.
    logic [WIDTH-1:0] q_arr [SLOTS];
    logic [SLOTS-1:0] lock_vec;
    logic [SLOTS-1:0] wrap_vec;

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < DEPTH) begin : g_cell
                logic sel;
                assign sel = we && (waddr == ADDR_W'(gi));

                register_cell #(
                    .WIDTH (WIDTH),
                    .RESET (RESET)
                ) u_cell (
                    .clock  (clock),
                    .reset  (reset),
                    .sel    (sel),
                    .cmd    (cmd),
                    .wdata  (wdata),
                    .q      (q_arr[gi]),
                    .locked (lock_vec[gi]),
                    .wrap   (wrap_vec[gi])
                );

                assign q_all[gi*WIDTH +: WIDTH] = q_arr[gi];
                assign locked[gi]               = lock_vec[gi];
            end else begin : g_pad
                assign q_arr[gi]    = '0;
                assign lock_vec[gi] = 1'b0;
                assign wrap_vec[gi] = 1'b0;
            end
        end
    endgenerate

    logic             addr_ok;
    logic             value_op;
    logic             target_locked;
    logic             accept_val;
    logic             err_next;
    logic             carry_next;
    logic [WIDTH-1:0] fwd_value;
    logic [WIDTH-1:0] rdata_next;
    logic [WIDTH-1:0] rdata_reg;
    logic             err_reg;
    logic             carry_reg;

    assign addr_ok       = (int'(waddr) < DEPTH);
    assign value_op      = (cmd <= CMD_INC);
    assign target_locked = lock_vec[waddr];
    assign accept_val    = we && addr_ok && value_op && !target_locked;

    // Lock/unlock are never rejected in range; nop never reports anything.
    assign err_next   = we && (cmd != CMD_NOP) && (!addr_ok || (value_op && target_locked));
    assign carry_next = |wrap_vec;

    assign fwd_value  = WIDTH'(next_value(cmd, 32'(q_arr[waddr]), 32'(wdata)));
    assign rdata_next = (accept_val && (raddr == waddr)) ? fwd_value : q_arr[raddr];

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            rdata_reg <= RESET_VAL;
            err_reg   <= 1'b0;
            carry_reg <= 1'b0;
        end else begin
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
            carry_reg <= carry_next;
        end
    end

    assign rdata = rdata_reg;
    assign err   = err_reg;
    assign carry = carry_reg;

endmodule

// File: tb/tb_register_bank.sv
// Randomized and directed scoreboard bench for register_bank (WIDTH=8, DEPTH=3, ADDR_W=2).
module tb_register_bank;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 3;
    localparam int ADDR_W = 2;
    localparam int MAXV   = (1 << WIDTH) - 1;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic                   we    = 1'b0;
    logic [ADDR_W-1:0]      waddr = '0;
    logic [2:0]             cmd   = 3'b111;
    logic [WIDTH-1:0]       wdata = '0;
    logic [ADDR_W-1:0]      raddr = '0;
    logic [WIDTH-1:0]       rdata;
    logic [WIDTH*DEPTH-1:0] q_all;
    logic [DEPTH-1:0]       locked;
    logic                   err;
    logic                   carry;

    register_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET(0)) dut (
        .clock  (clock),
        .reset  (reset),
        .we     (we),
        .waddr  (waddr),
        .cmd    (cmd),
        .wdata  (wdata),
        .raddr  (raddr),
        .rdata  (rdata),
        .q_all  (q_all),
        .locked (locked),
        .err    (err),
        .carry  (carry)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [WIDTH-1:0]       rdata;
        logic [WIDTH*DEPTH-1:0] q_all;
        logic [DEPTH-1:0]       locked;
        logic                   err;
        logic                   carry;
    } exp_t;

    exp_t exp_q[$];
    int   mem[DEPTH];
    bit   lk[DEPTH];
    int   m_rdata;
    bit   m_err;
    bit   m_carry;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic sample_now = 1'b0;

    function automatic exp_t snapshot();
        exp_t e;
        e.rdata  = WIDTH'(m_rdata);
        e.q_all  = '0;
        e.locked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            e.q_all[i*WIDTH +: WIDTH] = WIDTH'(mem[i]);
            e.locked[i]               = lk[i];
        end
        e.err   = m_err;
        e.carry = m_carry;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 0;
            lk[i]  = 1'b0;
        end
        m_rdata = 0;
        m_err   = 1'b0;
        m_carry = 1'b0;
    endtask

    // Reference behaviour: one falling edge with the given operation.
    task automatic model_edge(input bit w, input int a, input int c, input int d, input int r);
        m_err   = 1'b0;
        m_carry = 1'b0;
        if (w && c != 7) begin
            if (a >= DEPTH)         m_err = 1'b1;
            else if (c == 5)        lk[a] = 1'b1;
            else if (c == 6)        lk[a] = 1'b0;
            else if (lk[a])         m_err = 1'b1;
            else begin
                case (c)
                    0: mem[a] = d;
                    1: mem[a] = mem[a] | d;
                    2: mem[a] = mem[a] & (MAXV - d);
                    3: mem[a] = mem[a] ^ d;
                    default: begin
                        if (mem[a] == MAXV) m_carry = 1'b1;
                        mem[a] = (mem[a] + 1) % (MAXV + 1);
                    end
                endcase
            end
        end
        m_rdata = (r < DEPTH) ? mem[r] : 0;
    endtask

    task automatic op(input bit w, input int a, input int c, input int d, input int r);
        @(posedge clock);
        #1;
        we    = w;
        waddr = ADDR_W'(a);
        cmd   = 3'(c);
        wdata = WIDTH'(d);
        raddr = ADDR_W'(r);
        @(negedge clock);
        #1;
        model_edge(w, a, c, d, r);
        exp_q.push_back(snapshot());
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_and_sample();
        exp_q.push_back(snapshot());
        sample_now = 1'b1;
        #1;
        sample_now = 1'b0;
    endtask

    // Monitor: compares every presented output set against the scoreboard queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock or posedge sample_now);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (rdata !== e.rdata || q_all !== e.q_all || locked !== e.locked ||
                    err !== e.err || carry !== e.carry) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got rdata=%h q_all=%h locked=%b err=%b carry=%b, expected rdata=%h q_all=%h locked=%b err=%b carry=%b",
                             $time, rdata, q_all, locked, err, carry,
                             e.rdata, e.q_all, e.locked, e.err, e.carry);
                end else begin
                    $display("t=%0t ok rdata=%h q_all=%h locked=%b err=%b carry=%b",
                             $time, rdata, q_all, locked, err, carry);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH*DEPTH-1:0] q_before;
        int                     drain;

        model_reset();
        #2;
        push_and_sample();
        @(posedge clock);
        #1 reset = 1'b0;

        // Read-modify-write chain on reg2
        op(1, 2, 0, 8'hA5, 2); check("load_a5", 32'(q_all[2*WIDTH +: WIDTH]), 32'hA5);
        op(1, 2, 1, 8'h0F, 2); check("set_0f",  32'(q_all[2*WIDTH +: WIDTH]), 32'hAF);
        op(1, 2, 2, 8'h81, 2); check("clr_81",  32'(q_all[2*WIDTH +: WIDTH]), 32'h2E);
        op(1, 2, 3, 8'hFF, 2); check("tgl_ff",  32'(q_all[2*WIDTH +: WIDTH]), 32'hD1);
        check("chain_err", 32'(err), 32'd0);

        // Increment wrap on reg1
        op(1, 1, 0, 8'hFE, 1);
        op(1, 1, 4, 0, 1);     check("inc_ff", 32'(q_all[1*WIDTH +: WIDTH]), 32'hFF);
        check("inc_no_carry", 32'(carry), 32'd0);
        op(1, 1, 4, 0, 1);     check("inc_wrap", 32'(q_all[1*WIDTH +: WIDTH]), 32'h00);
        check("carry_pulse", 32'(carry), 32'd1);
        op(0, 0, 0, 0, 0);     check("carry_drop", 32'(carry), 32'd0);

        // Lock rule on reg0
        op(1, 0, 5, 0, 0);
        op(1, 0, 0, 8'h55, 0); check("locked_hold", 32'(q_all[WIDTH-1:0]), 32'h00);
        check("locked_err", 32'(err), 32'd1);
        op(1, 0, 6, 0, 0);     check("err_drop", 32'(err), 32'd0);
        op(1, 0, 0, 8'h55, 0); check("unlocked_load", 32'(q_all[WIDTH-1:0]), 32'h55);

        // Out-of-range write and read
        q_before = q_all;
        op(1, 3, 0, 8'hAA, 3);
        check("oor_err", 32'(err), 32'd1);
        check("oor_qall", 32'(q_all), 32'(q_before));
        check("oor_rdata", 32'(rdata), 32'd0);

        // Forwarding, then blocked forwarding while locked
        op(1, 1, 0, 8'h3C, 1); check("fwd", 32'(rdata), 32'h3C);
        op(1, 1, 5, 0, 1);
        op(1, 1, 0, 8'h99, 1); check("fwd_locked", 32'(rdata), 32'h3C);
        op(1, 1, 6, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            op(($urandom_range(0, 9) != 0), $urandom_range(0, 3), $urandom_range(0, 7),
               $urandom_range(0, MAXV), $urandom_range(0, 3));
        end

        // Asynchronous reset between edges with an operation pending
        @(posedge clock);
        #1;
        we = 1'b1; waddr = 2'd2; cmd = 3'b000; wdata = 8'h77; raddr = 2'd2;
        #1 reset = 1'b1;
        #1;
        model_reset();
        push_and_sample();
        @(negedge clock);
        @(posedge clock);
        #1;
        we = 1'b0;
        reset = 1'b0;
        op(0, 2, 0, 8'h77, 2);
        check("dropped_op", 32'(q_all[2*WIDTH +: WIDTH]), 32'h00);
        op(1, 2, 4, 0, 2);
        op(1, 0, 0, 8'h12, 2);

        drain = 0;
        while (exp_q.size() > 0 && drain < 20) begin
            @(negedge clock);
            drain++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
